rll27_encoder: RTL and testbench
================================

Name: rll27_encoder

Overview:
- Complete streaming RLL(2,7) encoder, rate 1/2: serial NRZ data in, serial channel bits out.
- Parses the input into the 7 variable-length RLL(2,7) words and emits the matching channel codewords MSB-first.
- Adds a valid/ready handshake, end-of-stream flush with zero padding, and a selectable NRZI line output.
- Sits between the serialiser and the line driver in the encode path. The matching decoder is a separate block.

Parameters:
- NRZI, default 0: 0 means line_o = raw channel bit; 1 means line_o toggles on every channel '1'.
- INIT_LEVEL, default 0: line_o level after reset when NRZI=1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- data_i  input  1  NRZ data bit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  encoder accepts data_i this cycle.
- flush_i  input  1  end-of-stream request, single-cycle pulse.
- line_o  output  1  channel bit (NRZ) or NRZI level.
- valid_o  output  1  line_o carries a channel bit this cycle.
- busy_o  output  1  prefix pending, output bits pending, or flush pending.

Behaviour:
- Code table, input -> channel bits:
  - 10 -> 0100
  - 11 -> 1000
  - 000 -> 000100
  - 010 -> 100100
  - 011 -> 001000
  - 0010 -> 00100100
  - 0011 -> 00001000
- Parser states: IDLE, S0, S1, S00, S01, S001.
  - IDLE: 0 -> S0, 1 -> S1.
  - S0: 0 -> S00, 1 -> S01.
  - S1: any bit completes a word (10 or 11) -> IDLE.
  - S00: 0 completes 000 -> IDLE; 1 -> S001.
  - S01: any bit completes a word (010 or 011) -> IDLE.
  - S001: any bit completes a word (0010 or 0011) -> IDLE.
- Handshake:
  - A bit is accepted on a clock edge where valid_i && ready_o.
  - ready_o = (out_cnt==0) || state in {IDLE, S0}. A bit that may complete a word is never accepted while output bits are pending.
  - ready_o is deasserted while a flush is pending.
- Output buffer:
  - 8-bit shift register plus out_cnt (0..8).
  - On completion, the codeword loads left-aligned and out_cnt = codeword length.
  - Every cycle with out_cnt>0: the MSB is shifted out, valid_o=1, out_cnt decrements. Output is one channel bit per cycle with no backpressure.
- Latency: the first channel bit of a word appears on valid_o the cycle after the accepting edge of its final input bit. All bits are registered outputs.
- Throughput: sustained input of 1 bit per 2 cycles runs with no stall.
- Flush:
  - flush_i sets sticky flush_pend.
  - Flush executes on the first cycle with out_cnt==0 and no accept in that cycle.
  - On execute: the pending prefix is completed with zero padding and the padded codeword is loaded.
    - S1 -> 10
    - S0 -> 000
    - S00 -> 000
    - S01 -> 010
    - S001 -> 0010
  - On execute, the parser returns to IDLE and flush_pend clears.
  - Flush in IDLE clears flush_pend and emits nothing.
  - flush_i coincident with an accepted bit: the bit is accepted first, and the flush executes later.
- NRZI:
  - NRZI=1: on each valid_o cycle with channel bit 1, line_o = ~previous level; with channel bit 0, the level is held. Level persists across idle gaps.
  - NRZI=0: line_o = channel bit when valid_o=1, else 0.
- Reset, asynchronous, any time including mid-codeword:
  - state=IDLE, out_cnt=0, flush_pend=0.
  - valid_o=0, ready_o=1, busy_o=0.
  - line_o = INIT_LEVEL if NRZI=1, else 0.
  - Partial words and pending bits are discarded.
- busy_o = (state!=IDLE) || (out_cnt!=0) || flush_pend.
- Invariant: concatenated output of any stream contains 2..7 zeros between consecutive ones. Word boundaries do not break this.

Test Plan:
- NRZI=0, input 1,0 then 1,1 at 1 bit per 2 cycles -> channel stream 0100 1000, valid_o contiguous over 8 cycles, ready_o never low on a valid cycle.
- NRZI=0, input 0,0,1,1 then 0,1,0 -> 00001000 100100. ready_o drops only for the last bit of each word if output is pending.
- Input 0,0,0,1,1 (000 then 11) back-to-back valid_i=1 -> 000100 1000; ready_o low while the 000100 drains before the '1' in S1 completes.
- Input 1 then flush_i pulse -> 0100 emitted, busy_o falls after last bit. Input 0,0,1 then flush -> 00100100. Flush in IDLE -> no valid_o.
- NRZI=1, INIT_LEVEL=0, input 1,0 -> line_o 0,1,1,1. Following 1,1 -> 0,0,0,0 (toggle on first '1' only).
- Assert rst_i mid-way through 00100100 output -> valid_o=0 immediately (async), line_o=INIT_LEVEL. After release, input 1,1 -> 1000 with no residue.
- Random 10k-bit stream plus flush -> golden-model match; run-length checker confirms d=2, k=7 across all word boundaries.

Source files
------------

// File: rtl/rll27_encoder.sv
// rll27_encoder: streaming rate-1/2 RLL(2,7) encoder, serial NRZ data in, serial channel bits out.
// Latency: first channel bit of a word is on valid_o/line_o the cycle after the edge accepting its last data bit.
// Backpressure: ready_o drops only while a word-completing bit would collide with pending output, or a flush is pending.
//
// Ports:
//   clk_i, rst_i        rising-edge clock, asynchronous active-high reset
//   data_i, valid_i     NRZ data bit and its valid; accepted when valid_i && ready_o
//   ready_o             encoder can take data_i this cycle
//   flush_i             single-cycle end-of-stream request (pads the pending prefix with zeros)
//   line_o, valid_o     channel bit (NRZ) or NRZI line level, and its valid
//   busy_o              prefix, output bits or flush still pending
module rll27_encoder #(
  parameter logic NRZI       = 1'b0,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  input  logic valid_i,
  output logic ready_o,
  input  logic flush_i,
  output logic line_o,
  output logic valid_o,
  output logic busy_o
);

  // Parser state = input prefix collected so far.
  typedef enum logic [2:0] {IDLE, S0, S1, S00, S01, S001} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;        // channel bits still to be presented, MSB next
  logic [3:0]  cnt_q, cnt_d;      // number of bits left in sr_q
  logic        flush_pend_q, flush_pend_d;
  logic        valid_q;
  logic        line_q, line_d;

  logic        accept;
  logic        flush_go;
  logic        cw_vld;
  logic [7:0]  cw_dat;            // codeword, left-aligned
  logic [3:0]  cw_rem;            // codeword length minus the bit presented at once
  logic        out_vld_d;
  logic        chan_bit;

  // Only prefixes that cannot complete a word may be accepted while bits are still draining.
  assign ready_o = !flush_pend_q &&
                   ((cnt_q == 4'd0) || (state_q == IDLE) || (state_q == S0));
  assign accept  = valid_i && ready_o;

  // ready_o is low while flush is pending, so no accept can coincide with the flush.
  assign flush_go = flush_pend_q && (cnt_q == 4'd0);

  assign busy_o  = (state_q != IDLE) || (cnt_q != 4'd0) || valid_q || flush_pend_q;
  assign valid_o = valid_q;
  assign line_o  = line_q;

  // Parser: next state and codeword lookup.
  always_comb begin
    state_d = state_q;
    cw_vld  = 1'b0;
    cw_dat  = 8'h00;
    cw_rem  = 4'd0;
    if (flush_go) begin
      // Pad the pending prefix with zeros until it forms a complete word.
      state_d = IDLE;
      cw_vld  = (state_q != IDLE);
      case (state_q)
        S1:      begin cw_dat = 8'b0100_0000; cw_rem = 4'd3; end  // 10
        S0, S00: begin cw_dat = 8'b0001_0000; cw_rem = 4'd5; end  // 000
        S01:     begin cw_dat = 8'b1001_0000; cw_rem = 4'd5; end  // 010
        S001:    begin cw_dat = 8'b0010_0100; cw_rem = 4'd7; end  // 0010
        default: ;
      endcase
    end else if (accept) begin
      case (state_q)
        IDLE: state_d = data_i ? S1 : S0;
        S0:   state_d = data_i ? S01 : S00;
        S1: begin
          state_d = IDLE;
          cw_vld  = 1'b1;
          cw_dat  = data_i ? 8'b1000_0000 : 8'b0100_0000;         // 11 / 10
          cw_rem  = 4'd3;
        end
        S00: begin
          if (data_i) begin
            state_d = S001;
          end else begin
            state_d = IDLE;
            cw_vld  = 1'b1;
            cw_dat  = 8'b0001_0000;                                // 000
            cw_rem  = 4'd5;
          end
        end
        S01: begin
          state_d = IDLE;
          cw_vld  = 1'b1;
          cw_dat  = data_i ? 8'b0010_0000 : 8'b1001_0000;         // 011 / 010
          cw_rem  = 4'd5;
        end
        S001: begin
          state_d = IDLE;
          cw_vld  = 1'b1;
          cw_dat  = data_i ? 8'b0000_1000 : 8'b0010_0100;         // 0011 / 0010
          cw_rem  = 4'd7;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output buffer: a new codeword is only produced when the buffer is empty, so its
  // first bit goes straight to the output register and the rest follow back-to-back.
  always_comb begin
    out_vld_d = 1'b0;
    chan_bit  = 1'b0;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    if (cw_vld) begin
      out_vld_d = 1'b1;
      chan_bit  = cw_dat[7];
      sr_d      = {cw_dat[6:0], 1'b0};
      cnt_d     = cw_rem;
    end else if (cnt_q != 4'd0) begin
      out_vld_d = 1'b1;
      chan_bit  = sr_q[7];
      sr_d      = {sr_q[6:0], 1'b0};
      cnt_d     = cnt_q - 4'd1;
    end
  end

  always_comb begin
    if (NRZI) begin
      line_d = line_q ^ (out_vld_d & chan_bit);   // level persists across idle gaps
    end else begin
      line_d = out_vld_d & chan_bit;
    end
  end

  // A flush request arriving on the executing edge stays pending (it then retires harmlessly in IDLE).
  assign flush_pend_d = flush_i || (flush_pend_q && !flush_go);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sr_q         <= 8'h00;
      cnt_q        <= 4'd0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      line_q       <= NRZI ? INIT_LEVEL : 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= out_vld_d;
      line_q       <= line_d;
    end
  end

endmodule

// File: tb/tb_rll27_encoder.sv
// tb_rll27_encoder: directed and random checks of rll27_encoder, NRZ and NRZI instances side by side.
// Both instances share stimulus; channel bits are collected on the falling edge.
// Random traffic is compared against a table-driven prefix-code model.
module tb_rll27_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data = 1'b0;
  logic vld = 1'b0;
  logic flush = 1'b0;

  logic rdy0, line0, vo0, busy0;
  logic rdy1, line1, vo1, busy1;

  always #5 clk = ~clk;

  rll27_encoder #(.NRZI(1'b0), .INIT_LEVEL(1'b0)) u_nrz (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld), .ready_o(rdy0),
    .flush_i(flush), .line_o(line0), .valid_o(vo0), .busy_o(busy0)
  );

  rll27_encoder #(.NRZI(1'b1), .INIT_LEVEL(1'b0)) u_nrzi (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld), .ready_o(rdy1),
    .flush_i(flush), .line_o(line1), .valid_o(vo1), .busy_o(busy1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic got_q[$];     // NRZ channel bits
  logic gotn_q[$];    // NRZI line levels on valid cycles
  int   vcyc_q[$];    // cycle numbers of NRZ valid cycles

  always @(negedge clk) begin
    cyc++;
    if (vo0 === 1'b1) begin
      got_q.push_back(line0);
      vcyc_q.push_back(cyc);
    end
    if (vo1 === 1'b1) gotn_q.push_back(line1);
  end

  // Code table: input word (length, value) -> channel word (length, value).
  localparam int         W_LEN [7] = '{2, 2, 3, 3, 3, 4, 4};
  localparam int         W_VAL [7] = '{2, 3, 0, 2, 3, 2, 3};
  localparam int         C_LEN [7] = '{4, 4, 6, 6, 6, 8, 8};
  localparam logic [7:0] C_VAL [7] = '{8'b0100, 8'b1000, 8'b000100, 8'b100100,
                                       8'b001000, 8'b00100100, 8'b00001000};

  logic exp_q[$];
  int   pre_len = 0;
  int   pre_val = 0;

  function automatic void model_match();
    logic [7:0] c;
    for (int i = 0; i < 7; i++) begin
      if (pre_len == W_LEN[i] && pre_val == W_VAL[i]) begin
        c = C_VAL[i];
        for (int j = C_LEN[i] - 1; j >= 0; j--) exp_q.push_back(c[j]);
        pre_len = 0;
        pre_val = 0;
        return;
      end
    end
  endfunction

  function automatic void model_bit(input logic b);
    pre_val = pre_val * 2 + int'(b);
    pre_len++;
    model_match();
  endfunction

  function automatic void model_flush();
    while (pre_len != 0 && pre_len < 8) begin
      pre_val = pre_val * 2;
      pre_len++;
      model_match();
    end
  endfunction

  function automatic string q2s(input logic q[$]);
    string s = "";
    foreach (q[i]) s = {s, (q[i] === 1'b1) ? "1" : (q[i] === 1'b0) ? "0" : "x"};
    return s;
  endfunction

  task automatic clear_q();
    got_q.delete();
    gotn_q.delete();
    vcyc_q.delete();
  endtask

  // Present one bit (optionally with a coincident flush) until accepted, then idle for gap cycles.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send_bit(input logic b, input logic fl, input int gap, output int stalls);
    data = b;
    vld = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (rdy0 === 1'b1) break;
      stalls++;
      if (stalls > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_bit_timeout: ready_o=%b after %0d cycles, required 1", rdy0, stalls);
        break;
      end
    end
    flush = fl;
    @(posedge clk); #1;
    vld = 1'b0; flush = 1'b0; data = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Wait for output and parser to go quiet, bounded; ends 1 time unit after a rising edge.
  task automatic wait_idle(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (busy0 === 1'b0 && vo0 === 1'b0) break;
      n++;
      if (n > budget) begin
        n_cmp++; n_err++;
        $display("FAIL wait_idle_timeout: busy_o=%b valid_o=%b, required 0/0", busy0, vo0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (vo0 !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b want 0", vo0); end
    n_cmp++; if (rdy0 !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (line0 !== 1'b0) begin n_err++; $display("FAIL reset_line_nrz: got %b want 0", line0); end
    n_cmp++; if (line1 !== 1'b0) begin n_err++; $display("FAIL reset_line_nrzi: got %b want 0", line1); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_nrzi();
    int s;
    clear_q();
    send_bit(1'b1, 1'b0, 1, s);
    send_bit(1'b0, 1'b0, 1, s);
    wait_idle(40);
    n_cmp++; if (q2s(gotn_q) != "0111") begin n_err++; $display("FAIL nrzi_10: got %s want 0111", q2s(gotn_q)); end
    n_cmp++; if (q2s(got_q) != "0100")  begin n_err++; $display("FAIL nrz_10: got %s want 0100", q2s(got_q)); end
    clear_q();
    send_bit(1'b1, 1'b0, 1, s);
    send_bit(1'b1, 1'b0, 1, s);
    wait_idle(40);
    n_cmp++; if (q2s(gotn_q) != "0000") begin n_err++; $display("FAIL nrzi_11: got %s want 0000", q2s(gotn_q)); end
  endtask

  task automatic test_basic();
    int s;
    int tot = 0;
    logic b[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send_bit(b[i], 1'b0, 1, s);
      tot += s;
    end
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "01001000") begin n_err++; $display("FAIL basic_stream: got %s want 01001000", q2s(got_q)); end
    n_cmp++; if (tot !== 0) begin n_err++; $display("FAIL basic_stall: got %0d stall cycles want 0", tot); end
    n_cmp++;
    if (vcyc_q.size() != 8 || vcyc_q[vcyc_q.size()-1] - vcyc_q[0] != 7) begin
      n_err++; $display("FAIL basic_contiguous: got %0d valid cycles, not 8 contiguous", vcyc_q.size());
    end
  endtask

  task automatic test_mixed();
    int s;
    int early = 0;
    int last_stall = 0;
    logic b[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_q();
    for (int i = 0; i < 7; i++) begin
      send_bit(b[i], 1'b0, 0, s);
      if (i == 3 || i == 6) last_stall += s; else early += s;
    end
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "00001000100100") begin n_err++; $display("FAIL mixed_stream: got %s want 00001000100100", q2s(got_q)); end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL mixed_prefix_stall: got %0d want 0", early); end
    n_cmp++; if (last_stall == 0) begin n_err++; $display("FAIL mixed_final_stall: got %0d want >0", last_stall); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic b[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_q();
    for (int i = 0; i < 5; i++) send_bit(b[i], 1'b0, 0, s);
    wait_idle(40);
    n_cmp++; if (s == 0) begin n_err++; $display("FAIL b2b_stall: got %0d want >0", s); end
    n_cmp++; if (q2s(got_q) != "0001001000") begin n_err++; $display("FAIL b2b_stream: got %s want 0001001000", q2s(got_q)); end
    n_cmp++;
    if (vcyc_q.size() != 10 || vcyc_q[vcyc_q.size()-1] - vcyc_q[0] != 9) begin
      n_err++; $display("FAIL b2b_contiguous: got %0d valid cycles, not 10 contiguous", vcyc_q.size());
    end
  endtask

  task automatic test_flush();
    int s;
    clear_q();
    send_bit(1'b1, 1'b0, 0, s);
    pulse_flush();
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "0100") begin n_err++; $display("FAIL flush_s1: got %s want 0100", q2s(got_q)); end
    @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy0); end
    @(posedge clk); #1;

    clear_q();
    send_bit(1'b0, 1'b0, 0, s);
    send_bit(1'b0, 1'b0, 0, s);
    send_bit(1'b1, 1'b0, 0, s);
    pulse_flush();
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "00100100") begin n_err++; $display("FAIL flush_s001: got %s want 00100100", q2s(got_q)); end

    clear_q();
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL flush_idle: got %0d channel bits want 0", got_q.size()); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy: got %b want 0", busy0); end

    clear_q();
    send_bit(1'b0, 1'b1, 0, s);    // bit accepted first, then padded 0 -> 000
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "000100") begin n_err++; $display("FAIL flush_coincident: got %s want 000100", q2s(got_q)); end
  endtask

  task automatic test_reset_mid();
    int s;
    logic b[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    clear_q();
    for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0, 0, s);
    repeat (2) @(negedge clk);
    n_cmp++; if (vo0 !== 1'b1) begin n_err++; $display("FAIL rstmid_active: valid_o got %b want 1", vo0); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (vo0 !== 1'b0)   begin n_err++; $display("FAIL rstmid_valid: got %b want 0", vo0); end
    n_cmp++; if (line1 !== 1'b0) begin n_err++; $display("FAIL rstmid_nrzi_level: got %b want 0", line1); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    send_bit(1'b1, 1'b0, 0, s);
    send_bit(1'b1, 1'b0, 0, s);
    wait_idle(40);
    n_cmp++; if (q2s(got_q) != "1000") begin n_err++; $display("FAIL rstmid_after: got %s want 1000", q2s(got_q)); end
  endtask

  task automatic test_random();
    int s;
    int bad = 0;
    int badn = 0;
    int viol = 0;
    int last_one = -1;
    logic lev = 1'b0;
    logic b;
    logic fl;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    exp_q.delete();
    pre_len = 0;
    pre_val = 0;
    for (int i = 0; i < 10000; i++) begin
      b  = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 63) == 0);
      send_bit(b, fl, $urandom_range(0, 2), s);
      model_bit(b);
      if (fl) model_flush();
      if ($urandom_range(0, 63) == 0) begin
        pulse_flush();
        model_flush();
      end
    end
    pulse_flush();
    model_flush();
    wait_idle(60);

    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_length: got %0d channel bits want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (bad == 0) $display("first difference at channel bit %0d: got %b want %b", i, got_q[i], exp_q[i]);
        bad++;
      end
      if (exp_q[i] === 1'b1) lev = ~lev;
      if (i < gotn_q.size() && gotn_q[i] !== lev) badn++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_stream: got %0d differing bits want 0", bad); end
    n_cmp++;
    if (badn != 0 || gotn_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_nrzi: got %0d differing levels of %0d want 0 of %0d", badn, gotn_q.size(), exp_q.size());
    end

    foreach (got_q[i]) begin
      if (got_q[i] === 1'b1) begin
        if (last_one >= 0 && (i - last_one - 1 < 2 || i - last_one - 1 > 7)) viol++;
        last_one = i;
      end
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rand_runlength: got %0d d/k violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_nrzi();
    test_basic();
    test_mixed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
